button_event_ctrl: RTL

Debounces the eight front-panel inputs (pb0–pb4, eq0–eq2), turns each debounced press into a latched pending event and raises a single interrupt request to the processor fetch stage. Software reads and clears events through a four-word memory-mapped window decoded by the MMU. The block sits directly upstream of the processor interrupt logic and of the MMU I/O read path, between the raw pins and the firmware.

---
 rtl/button_event_ctrl_if.sv | 21 ++
 rtl/button_event_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl_if.sv
// MMU load/store window and interrupt handshake for button_event_ctrl.
// master: MMU/processor side; slave: the button controller.
interface button_event_ctrl_if;
  logic        cs;
  logic        iorw;
  logic [1:0]  addr;
  logic [23:0] wdata;
  logic [23:0] rdata;
  logic        int_req;
  logic        int_ack;

  modport master (
    output cs, iorw, addr, wdata, int_ack,
    input  rdata, int_req
  );

  modport slave (
    input  cs, iorw, addr, wdata, int_ack,
    output rdata, int_req
  );
endinterface

// File: rtl/button_event_ctrl.sv
// Front-panel debounce, pending-event latch and interrupt request.
// Define BTN_AUTOREPEAT_EN to add auto-repeat on pb1/pb2.
module button_event_ctrl #(
  parameter logic [15:0] DB_CYCLES     = 16'd50000,
  parameter int          DB_CNT_W      = 16,
  parameter logic [23:0] REPEAT_CYCLES = 24'd5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          btn_in,
  button_event_ctrl_if.slave  bus
);

  localparam logic [DB_CNT_W-1:0] DB_LAST =
    DB_CNT_W'(DB_CYCLES - 16'd1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t              state;
  logic [7:0]          sync1;
  logic [7:0]          sync2;
  logic [7:0]          stable;
  logic [7:0]          rose;
  logic [7:0]          block;
  logic [7:0]          pending;
  logic [7:0]          mask;
  logic [23:0]         rdata_q;
  logic                int_req_q;
  logic [1:0]          settle;
  logic [DB_CNT_W-1:0] cnt [8];

  logic [7:0] accept;
  logic [7:0] clr;
  logic [7:0] rpt;
  logic [7:0] rd_val;
  logic       rd;
  logic       wr;
  logic       clr_wr;
  logic       active;
  logic       settled;
  logic       unused_ok;

  assign rd        = bus.cs & bus.iorw;
  assign wr        = bus.cs & ~bus.iorw;
  assign clr_wr    = wr & (bus.addr == 2'd2);
  assign clr       = clr_wr ? bus.wdata[7:0] : 8'h00;
  assign active    = |(pending & mask);
  assign settled   = settle[1];
  assign unused_ok = ^{bus.wdata[23:8], REPEAT_CYCLES};

  assign bus.rdata   = rdata_q;
  assign bus.int_req = int_req_q;

  always_comb begin
    accept = '0;
    for (int i = 0; i < 8; i++) begin
      accept[i] = (sync2[i] != stable[i]) &&
                  (cnt[i] == DB_LAST);
    end
  end

  always_comb begin
    rd_val = 8'h00;
    unique case (bus.addr)
      2'd0: rd_val = pending;
      2'd1: rd_val = mask;
      2'd2: rd_val = 8'h00;
      2'd3: rd_val = stable;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [23:0] rep [1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rep[1] <= '0;
      rep[2] <= '0;
    end else begin
      for (int i = 1; i <= 2; i++) begin
        if (!stable[i] || block[i])
          rep[i] <= '0;
        else if (rep[i] == REPEAT_CYCLES)
          rep[i] <= 24'd1;
        else
          rep[i] <= rep[i] + 24'd1;
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int i = 1; i <= 2; i++) begin
      rpt[i] = stable[i] & ~block[i] &
               (rep[i] == REPEAT_CYCLES);
    end
  end
`else
  assign rpt = '0;
`endif

  // Debounce: a level is taken only after DB_CYCLES mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      rose   <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      rose  <= accept & sync2 & ~block;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else if (cnt[i] != '1) begin
          cnt[i] <= cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // A bit held through reset stays blocked until seen released.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle <= '0;
      block  <= '1;
    end else begin
      if (!settled) settle <= settle + 2'd1;
      if (settled) block <= block & ~(~stable & ~sync2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      mask    <= 8'hFF;
      rdata_q <= '0;
    end else begin
      pending <= (pending & ~clr) | rose | rpt;
      if (wr && bus.addr == 2'd1) mask <= bus.wdata[7:0];
      if (rd) rdata_q <= {16'h0000, rd_val};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      int_req_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (active) begin
            state     <= REQ;
            int_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state     <= SERVICE;
            int_req_q <= 1'b0;
          end else if (!active) begin
            state     <= IDLE;
            int_req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (clr_wr) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
